segway_math_seq: RTL
====================

// Module: segway_math_seq
// PURPOSE
//  Power/soft-start sequencer for the balance-math datapath (4 register stages, PID/ss_tmr -> lft/rght_spd).
//  Generates pwr_up, ss_tmr and en_steer, and ramps ss_tmr up on mount and down on dismount.
//  Tracks pipeline latency to produce spd_vld, and handles the overspeed (too_fast) condition.
// PARAMETERS
//  SS_DIV    1024  clk cycles per ss_tmr step (>=2)
//  PIPE_LAT  4     datapath latency in clk cycles, PID sample -> lft/rght_spd
//  TF_CNT    3     consecutive valid samples needed to enter/exit overspeed (1..15)
// PORTS
//  clk       in   1  clock
//  rst_n     in   1  asynchronous, active-low reset
//  pwr_req   in   1  rider power switch, level
//  rider_on  in   1  load cells report rider present, level
//  steer_req in   1  steering allowed by load balance, level
//  pid_vld   in   1  one-cycle strobe: new PID_cntrl presented to datapath
//  too_fast  in   1  from datapath, meaningful only on spd_vld cycles
//  pwr_up    out  1  datapath enable
//  ss_tmr    out  8  soft-start scale, 0..255
//  en_steer  out  1  steering enable to datapath
//  spd_vld   out  1  lft/rght_spd valid strobe
//  ovrspd    out  1  overspeed flag (status/buzzer)
// BEHAVIOUR
//  Reset: state=IDLE; pwr_up=0, ss_tmr=0, en_steer=0, spd_vld=0, ovrspd=0; prescaler=0, tf counter=0, vld shift reg=0.
//  All outputs registered. Prescaler wraps at SS_DIV-1 and emits tick; it is cleared on every state change.
//  IDLE:   pwr_req&rider_on -> RAMP next cycle.
//  RAMP:   pwr_up=1, en_steer=0; ss_tmr+=1 per tick. Reaching 255 -> RUN. Exit to SHUTDN if !pwr_req|!rider_on.
//  RUN:    ss_tmr held at 255; en_steer=steer_req (registered, 1 cycle). Exit to SHUTDN on !pwr_req|!rider_on.
//          TF_CNT consecutive spd_vld cycles with too_fast=1 -> OVRSPD.
//  OVRSPD: ovrspd=1, en_steer=0, ss_tmr held. TF_CNT consecutive spd_vld cycles with too_fast=0 -> RUN.
//          Exit to SHUTDN on !pwr_req|!rider_on.
//  SHUTDN: en_steer=0; ss_tmr-=1 per tick. At 0 -> IDLE (pwr_up drops the same cycle state becomes IDLE).
//          pwr_req&rider_on reasserted -> RAMP, continuing from the current ss_tmr (no jump).
//  Precedence: dismount (SHUTDN) beats overspeed. ss_tmr never wraps: saturates at 0 and 255.
//  tf counter: 4-bit; counts matching samples, clears on a mismatching sample and on any state change.
//    A cycle without spd_vld leaves it unchanged.
//  spd_vld = pid_vld delayed PIPE_LAT cycles AND pwr_up; delay line keeps shifting in every state.
//    Strobes in flight when pwr_up falls are suppressed.
//  pid_vld on consecutive cycles is legal; each strobe yields exactly one spd_vld.
//  Reset mid-operation: everything returns to reset values immediately (async); no ramp-down.
// CONFIGURATION
//  OVRSPD_LATCH_EN defined:
//    ovrspd is sticky once set, cleared only by rst_n or on entry to IDLE.
//    The OVRSPD->RUN transition is unchanged.
//  Not defined: ovrspd=1 exactly while state==OVRSPD.
// STRUCTURE
//  Package segway_pkg: typedef enum logic[2:0] seq_state_t {IDLE,RAMP,RUN,OVRSPD,SHUTDN}; localparam SS_MAX=8'hFF.
//  Sub-module ss_ramp_cnt: prescaler plus up/down saturating 8-bit counter.
//    Inputs: up, dn, clr_pre. Outputs: ss_tmr, at_max, at_zero.
//  Top: FSM, tf counter, PIPE_LAT valid shift register.
// TESTING
//  1 SS_DIV=4: pwr_req=rider_on=1 from IDLE -> RAMP next cycle; ss_tmr=255 after 1020 cycles; then RUN; en_steer follows steer_req after 1 cycle.
//  2 In RUN, pid_vld pulse at cycle t -> spd_vld exactly at t+4. Back-to-back pulses at t,t+1 -> spd_vld at t+4,t+5.
//  3 too_fast=1 on 3 spd_vld samples -> OVRSPD, ovrspd=1, en_steer=0.
//    Pattern 1,1,0,1,1 -> no entry. 3 clean samples -> RUN.
//  4 rider_on drops at ss_tmr=255 -> SHUTDN, ss_tmr counts down to 0 in 1020 cycles, then IDLE with pwr_up=0.
//    Re-mount at ss_tmr=100 -> RAMP upward from 100.
//  5 rst_n asserted mid-RAMP (ss_tmr=37) -> all outputs 0 with no clock edge; IDLE after release.
//  6 OVRSPD_LATCH_EN: enter then exit OVRSPD -> ovrspd stays 1 in RUN, clears on return to IDLE.

Source files
------------

// File: rtl/segway_pkg.sv
// Shared types and constants for the balance-math power/soft-start sequencer.
package segway_pkg;

  // Sequencer operating states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RAMP   = 3'd1,
    RUN    = 3'd2,
    OVRSPD = 3'd3,
    SHUTDN = 3'd4
  } seq_state_t;

  // Soft-start scale limits; ss_tmr saturates at both ends.
  localparam logic [7:0] SS_MAX = 8'hFF;
  localparam logic [7:0] SS_MIN = 8'h00;

endpackage

// File: rtl/ss_ramp_cnt.sv
// Soft-start ramp counter: a free-running prescaler that emits one tick every
// SS_DIV cycles, and an 8-bit up/down counter that saturates at 0 and 255.
// clr_pre_i restarts the prescaler so every new state gets a full first step.
module ss_ramp_cnt
  import segway_pkg::*;
#(
  parameter int unsigned SS_DIV = 1024   // clk cycles per ss_tmr step, >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up_i,
  input  logic       dn_i,
  input  logic       clr_pre_i,
  output logic [7:0] ss_tmr_o,
  output logic       at_max_o,
  output logic       at_zero_o
);

  localparam int PRE_W = (SS_DIV > 2) ? $clog2(SS_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(SS_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       ss_q, ss_d;
  logic             tick;

  assign tick = (pre_q == PRE_TOP);

  // Next-state logic for prescaler and soft-start counter.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pre_d = pre_q + 1'b1;
    ss_d  = ss_q;
    if (clr_pre_i || tick) begin
      pre_d = '0;
    end
    if (tick) begin
      if (up_i && (ss_q != SS_MAX)) begin
        ss_d = ss_q + 8'd1;
      end else if (dn_i && (ss_q != SS_MIN)) begin
        ss_d = ss_q - 8'd1;
      end
    end
  end

  // Prescaler and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      ss_q  <= SS_MIN;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      pre_q <= pre_d;
      ss_q  <= ss_d;
    end
  end

  assign ss_tmr_o  = ss_q;
  assign at_max_o  = (ss_q == SS_MAX);
  assign at_zero_o = (ss_q == SS_MIN);

endmodule

// File: rtl/segway_math_seq.sv
// Power/soft-start sequencer for the balance-math datapath.
// Drives pwr_up, ss_tmr and en_steer, ramps ss_tmr on mount/dismount, tracks
// datapath latency to produce spd_vld and debounces the overspeed condition.
// Optional build macro OVRSPD_LATCH_EN: ovrspd becomes sticky until reset or
// until the sequencer returns to IDLE.
module segway_math_seq
  import segway_pkg::*;
#(
  parameter int unsigned SS_DIV   = 1024, // clk cycles per ss_tmr step, >= 2
  parameter int unsigned PIPE_LAT = 4,    // pid_vld -> spd_vld latency, >= 2
  parameter int unsigned TF_CNT   = 3     // consecutive samples to enter/exit overspeed, 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_req,
  input  logic       rider_on,
  input  logic       steer_req,
  input  logic       pid_vld,
  input  logic       too_fast,
  output logic       pwr_up,
  output logic [7:0] ss_tmr,
  output logic       en_steer,
  output logic       spd_vld,
  output logic       ovrspd
);

  localparam logic [3:0] TF_TOP = 4'(TF_CNT - 1);

  seq_state_t state_q, state_d;
  logic       state_chg;
  logic       mount;

  logic       at_max, at_zero;

  logic [3:0] tf_cnt_q, tf_cnt_d;
  logic       tf_judge, tf_match, tf_hit;

  // Last stage of the latency pipe is spd_vld_q itself.
  logic [PIPE_LAT-2:0] vld_sr_q, vld_sr_d;

  logic pwr_up_q, pwr_up_d;
  logic en_steer_q, en_steer_d;
  logic spd_vld_q, spd_vld_d;
  logic ovrspd_q, ovrspd_d;

  assign mount = pwr_req & rider_on;

  // Overspeed qualification: only spd_vld samples in RUN/OVRSPD count; in RUN a
  // sample matches when too_fast is high, in OVRSPD when it is low.
  assign tf_judge = spd_vld_q && ((state_q == RUN) || (state_q == OVRSPD));
  assign tf_match = (state_q == OVRSPD) ? ~too_fast : too_fast;
  assign tf_hit   = tf_judge && tf_match && (tf_cnt_q == TF_TOP);

  // Next-state decode; dismount is checked first so it beats overspeed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mount)        state_d = RAMP;
      RAMP:    if (!mount)       state_d = SHUTDN;
               else if (at_max)  state_d = RUN;
      RUN:     if (!mount)       state_d = SHUTDN;
               else if (tf_hit)  state_d = OVRSPD;
      OVRSPD:  if (!mount)       state_d = SHUTDN;
               else if (tf_hit)  state_d = RUN;
      SHUTDN:  if (mount)        state_d = RAMP;
               else if (at_zero) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  assign state_chg = (state_d != state_q);

  // Consecutive-sample counter: cleared on any state change or mismatching
  // sample, held on cycles without a judged sample.
  always_comb begin
    tf_cnt_d = tf_cnt_q;
    if (state_chg) begin
      tf_cnt_d = '0;
    end else if (tf_judge) begin
      tf_cnt_d = tf_match ? (tf_cnt_q + 4'd1) : 4'd0;
    end
  end

  // Latency delay line shifts in every state; pwr_up gates only the output.
  always_comb begin
    vld_sr_d    = vld_sr_q;
    vld_sr_d[0] = pid_vld;
    for (int i = 1; i < PIPE_LAT - 1; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    pwr_up_d   = (state_d != IDLE);
    en_steer_d = (state_d == RUN) && steer_req;
    spd_vld_d  = vld_sr_q[PIPE_LAT-2] && pwr_up_d;
`ifdef OVRSPD_LATCH_EN
    ovrspd_d   = (state_d == IDLE) ? 1'b0 : (ovrspd_q || (state_d == OVRSPD));
`else
    ovrspd_d   = (state_d == OVRSPD);
`endif
  end

  // State, counter, delay line and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tf_cnt_q   <= '0;
      vld_sr_q   <= '0;
      pwr_up_q   <= 1'b0;
      en_steer_q <= 1'b0;
      spd_vld_q  <= 1'b0;
      ovrspd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tf_cnt_q   <= tf_cnt_d;
      vld_sr_q   <= vld_sr_d;
      pwr_up_q   <= pwr_up_d;
      en_steer_q <= en_steer_d;
      spd_vld_q  <= spd_vld_d;
      ovrspd_q   <= ovrspd_d;
    end
  end

  ss_ramp_cnt #(
    .SS_DIV(SS_DIV)
  ) u_ss_ramp (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_i     (state_q == RAMP),
    .dn_i     (state_q == SHUTDN),
    .clr_pre_i(state_chg),
    .ss_tmr_o (ss_tmr),
    .at_max_o (at_max),
    .at_zero_o(at_zero)
  );

  assign pwr_up   = pwr_up_q;
  assign en_steer = en_steer_q;
  assign spd_vld  = spd_vld_q;
  assign ovrspd   = ovrspd_q;

endmodule
